// File: rtl/ps2_key_decoder_if.sv
// Byte-stream input and key status outputs of the PS/2 key decoder.
// The master drives scancode bytes; the slave (decoder) reports key state.
interface ps2_key_decoder_if;
    logic [7:0] received_data;
    logic       received_data_en;
    logic [2:0] key_held;
    logic [2:0] key_press;
    logic       seq_timeout;

    modport master (
        output received_data, received_data_en,
        input  key_held, key_press, seq_timeout
    );

    modport slave (
        input  received_data, received_data_en,
        output key_held, key_press, seq_timeout
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// Tracks PS/2 set-2 make/break sequences (with E0 prefix) for Enter, Left and Right,
// producing held levels, 0->1 press pulses and a prefix-timeout pulse.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int CNT_W          = 22
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    ps2_key_decoder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       held_q, held_d;
    logic [2:0]       press_q, press_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            held_q    <= '0;
            press_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            press_q   <= press_d;
            timeout_q <= timeout_d;
        end
    end

    // An arriving byte always takes precedence over a timeout expiring in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        timeout_d = 1'b0;

        if (bus.received_data_en) begin
            cnt_d = '0;
            if (bus.received_data == CODE_EXT) begin
                state_d = EXT;
            end else if (bus.received_data == CODE_BRK) begin
                if (state_q == IDLE)
                    state_d = BRK;
                else if (state_q == EXT)
                    state_d = EXT_BRK;
            end else begin
                state_d = IDLE;
                case (state_q)
                    IDLE: begin
                        if (bus.received_data == CODE_ENTER) held_d[2] = 1'b1;
                    end
                    EXT: begin
                        if (bus.received_data == CODE_LEFT)  held_d[1] = 1'b1;
                        if (bus.received_data == CODE_RIGHT) held_d[0] = 1'b1;
                    end
                    BRK: begin
                        if (bus.received_data == CODE_ENTER) held_d[2] = 1'b0;
                    end
                    EXT_BRK: begin
                        if (bus.received_data == CODE_LEFT)  held_d[1] = 1'b0;
                        if (bus.received_data == CODE_RIGHT) held_d[0] = 1'b0;
                    end
                    default: ;
                endcase
            end
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign press_d = held_d & ~held_q;

    assign bus.key_held    = held_q;
    assign bus.key_press   = press_q;
    assign bus.seq_timeout = timeout_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and randomized check of ps2_key_decoder against a prefix-flag reference model.
module tb_ps2_key_decoder;

    localparam int T = 16;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    // Reference model: prefix flags plus a count of idle cycles since the last byte
    bit         m_ext;
    bit         m_brk;
    int         m_wait;
    logic [2:0] m_held;
    logic [2:0] m_press;
    logic       m_to;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (5)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelStep(input logic en, input logic [7:0] data, input logic rst);
        logic [2:0] old_held;
        old_held = m_held;
        m_to     = 1'b0;
        if (rst) begin
            m_ext = 0; m_brk = 0; m_wait = 0;
            m_held = 3'b000; m_press = 3'b000;
            return;
        end
        if (en) begin
            m_wait = 0;
            if (data == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else if (data == 8'hF0) begin
                m_brk = 1;
            end else begin
                if (!m_ext && data == 8'h5A) m_held[2] = !m_brk;
                if (m_ext && data == 8'h6B)  m_held[1] = !m_brk;
                if (m_ext && data == 8'h74)  m_held[0] = !m_brk;
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_wait++;
            if (m_wait == T) begin
                m_ext = 0; m_brk = 0; m_wait = 0; m_to = 1'b1;
            end
        end
        m_press = m_held & ~old_held;
    endtask

    task automatic checkOutput(input string tag);
        tests_run++;
        assert (bus.key_held === m_held) else begin
            tests_failed++;
            $error("[TB] FAIL %s key_held observed=%b expected=%b", tag, bus.key_held, m_held);
        end
        tests_run++;
        assert (bus.key_press === m_press) else begin
            tests_failed++;
            $error("[TB] FAIL %s key_press observed=%b expected=%b", tag, bus.key_press, m_press);
        end
        tests_run++;
        assert (bus.seq_timeout === m_to) else begin
            tests_failed++;
            $error("[TB] FAIL %s seq_timeout observed=%b expected=%b", tag, bus.seq_timeout, m_to);
        end
    endtask

    task automatic checkValue(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic stepCycle(input logic en, input logic [7:0] data, input logic rst, input string tag);
        @(negedge clk);
        bus.received_data_en = en;
        bus.received_data    = data;
        reset                = rst;
        modelStep(en, data, rst);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input string tag);
        stepCycle(1'b1, data, 1'b0, tag);
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++)
            stepCycle(1'b0, 8'($urandom), 1'b0, tag);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        logic [7:0] pick [8];
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.received_data_en = 1'b0;
        bus.received_data    = 8'h00;
        m_ext = 0; m_brk = 0; m_wait = 0;
        m_held = '0; m_press = '0; m_to = 1'b0;

        stepCycle(1'b0, 8'h00, 1'b1, "reset");
        stepCycle(1'b0, 8'h00, 1'b1, "reset2");
        checkValue("reset_outputs", {bus.key_held, bus.seq_timeout}, 4'b0000);
        idleCycles(2, "post_reset");

        applyStimulus(8'h5A, "enter_make");
        checkValue("enter_press", {1'b0, bus.key_press}, 4'b0100);
        idleCycles(1, "enter_hold");
        applyStimulus(8'hF0, "enter_f0");
        applyStimulus(8'h5A, "enter_break");
        checkValue("enter_released", {1'b0, bus.key_held}, 4'b0000);

        applyStimulus(8'hE0, "left_e0");
        applyStimulus(8'h6B, "left_make");
        checkValue("left_press", {1'b0, bus.key_press}, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'hE0, "left_rep_e0");
            applyStimulus(8'h6B, "left_rep");
            checkValue("left_no_repulse", {bus.key_held, |bus.key_press}, 4'b0100);
        end
        applyStimulus(8'hE0, "left_brk_e0");
        applyStimulus(8'hF0, "left_brk_f0");
        applyStimulus(8'h6B, "left_break");
        checkValue("left_released", {1'b0, bus.key_held}, 4'b0000);

        applyStimulus(8'hE0, "right_e0");
        applyStimulus(8'h74, "right_make");
        applyStimulus(8'h5A, "enter_with_right");
        checkValue("two_held", {1'b0, bus.key_held}, 4'b0101);
        applyStimulus(8'hF0, "enter_f0b");
        applyStimulus(8'h5A, "enter_breakb");
        checkValue("right_only", {1'b0, bus.key_held}, 4'b0001);
        applyStimulus(8'hE0, "right_brk_e0");
        applyStimulus(8'hF0, "right_brk_f0");
        applyStimulus(8'h74, "right_break");

        applyStimulus(8'h6B, "keypad4");
        applyStimulus(8'h74, "keypad6");
        checkValue("keypad_ignored", {1'b0, bus.key_held}, 4'b0000);
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        foreach (pause_seq[i]) applyStimulus(pause_seq[i], "pause");

        applyStimulus(8'hE0, "to_e0");
        idleCycles(T - 1, "to_wait");
        idleCycles(1, "to_expire");
        checkValue("timeout_pulse", {3'b000, bus.seq_timeout}, 4'b0001);
        idleCycles(1, "to_after");
        applyStimulus(8'h6B, "to_plain_6b");
        checkValue("to_6b_ignored", {1'b0, bus.key_held}, 4'b0000);

        applyStimulus(8'hE0, "exact_e0");
        idleCycles(T - 1, "exact_wait");
        applyStimulus(8'h6B, "exact_byte");
        checkValue("exact_decoded", {bus.key_held, bus.seq_timeout}, 4'b0100);

        applyStimulus(8'hE0, "rst_e0");
        applyStimulus(8'hF0, "rst_f0");
        stepCycle(1'b0, 8'h00, 1'b1, "mid_reset");
        checkValue("mid_reset_clear", {bus.key_held, bus.seq_timeout}, 4'b0000);
        applyStimulus(8'h6B, "rst_6b");
        checkValue("rst_6b_ignored", {1'b0, bus.key_held}, 4'b0000);

        pick = '{8'hE0, 8'hF0, 8'h5A, 8'h6B, 8'h74, 8'h12, 8'hE1, 8'h00};
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 99));
            b = pick[$urandom_range(0, 7)];
            if (b == 8'h00) b = 8'($urandom);
            if (r < 2)
                stepCycle(1'b0, b, 1'b1, "rand_reset");
            else if (r < 6)
                idleCycles(int'($urandom_range(T - 2, T + 1)), "rand_gap");
            else if (r < 55)
                applyStimulus(b, "rand_byte");
            else
                stepCycle(1'b0, b, 1'b0, "rand_idle");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
